// File: rtl/vx_weighted_matrix_arbiter.sv
// Weighted least-recently-granted matrix arbiter with per-requester grant tenures and stall locking.
// Optional per-requester accepted-grant counters are enabled by defining WMARB_PERF_EN.
module vx_weighted_matrix_arbiter #(
  parameter int unsigned NUM_REQS       = 4,
  parameter int unsigned WEIGHT_WIDTH   = 2,
  parameter int unsigned PERF_CTR_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              requests,
  input  logic [NUM_REQS*WEIGHT_WIDTH-1:0] weights,
  input  logic                             grant_ready,
  output logic                             grant_valid,
  output logic [NUM_REQS-1:0]              grant_onehot,
  output logic [$clog2(NUM_REQS)-1:0]      grant_index,
  output logic                             grant_last
`ifdef WMARB_PERF_EN
  ,
  output logic [NUM_REQS*PERF_CTR_WIDTH-1:0] perf_grants
`endif
);

  localparam int unsigned IDXW = $clog2(NUM_REQS);
  localparam int unsigned NP   = NUM_REQS * (NUM_REQS - 1) / 2;

  if (NUM_REQS < 2 || PERF_CTR_WIDTH == 0) begin : g_cfg_err
    $error("vx_weighted_matrix_arbiter: NUM_REQS must be >= 2 and PERF_CTR_WIDTH > 0");
  end

  // Upper triangle of the priority matrix packed row by row: bit pidx(i,j), i<j, set when i beats j.
  function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
    return i * NUM_REQS - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic logic beats(input logic [NP-1:0] m, input int unsigned i, input int unsigned j);
    if (i < j) return m[pidx(i, j)];
    else       return !m[pidx(j, i)];
  endfunction

  function automatic logic [NP-1:0] demote(input logic [NP-1:0] m, input int unsigned k);
    logic [NP-1:0] r;
    r = m;
    for (int unsigned j = 0; j < NUM_REQS; j++) begin
      if (j < k)      r[pidx(j, k)] = 1'b1;
      else if (j > k) r[pidx(k, j)] = 1'b0;
    end
    return r;
  endfunction

  logic [NP-1:0]           r_prio;
  logic                    r_own_vld;
  logic [IDXW-1:0]         r_own_idx;
  logic [WEIGHT_WIDTH-1:0] r_credit;

  logic [NUM_REQS-1:0]     w_win_oh;
  logic [IDXW-1:0]         w_win_idx;
  logic [WEIGHT_WIDTH-1:0] w_win_wt;
  logic                    w_own_act;
  logic                    w_valid;
  logic                    w_fire;

  logic [NP-1:0]           w_prio_nxt;
  logic                    w_own_vld_nxt;
  logic [IDXW-1:0]         w_own_idx_nxt;
  logic [WEIGHT_WIDTH-1:0] w_credit_nxt;

  always_comb begin
    logic v_lose;
    w_win_oh  = '0;
    w_win_idx = '0;
    w_win_wt  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      v_lose = 1'b0;
      for (int unsigned j = 0; j < NUM_REQS; j++) begin
        if (j != i && requests[j] && beats(r_prio, j, i)) v_lose = 1'b1;
      end
      if (requests[i] && !v_lose) w_win_oh[i] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (w_win_oh[i]) begin
        w_win_idx = IDXW'(i);
        w_win_wt  = w_win_wt | weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  assign w_own_act = r_own_vld && requests[r_own_idx];
  // Outputs are gated by reset so they drop the instant reset asserts.
  assign w_valid   = reset && (|requests);
  assign w_fire    = w_valid && grant_ready;

  assign grant_valid  = w_valid;
  assign grant_index  = !w_valid ? '0 : (w_own_act ? r_own_idx : w_win_idx);
  assign grant_onehot = !w_valid ? '0 :
                        (w_own_act ? (NUM_REQS'(1) << r_own_idx) : w_win_oh);
  assign grant_last   = w_fire && (w_own_act ? (r_credit == '0) : (w_win_wt == '0));

  // A stale owner is demoted before the winner is handled, so a zero-weight winner ends up last.
  always_comb begin
    w_prio_nxt    = r_prio;
    w_own_vld_nxt = r_own_vld;
    w_own_idx_nxt = r_own_idx;
    w_credit_nxt  = r_credit;
    if (w_own_act) begin
      if (w_fire) begin
        if (r_credit != '0) begin
          w_credit_nxt = r_credit - 1'b1;
        end else begin
          w_own_vld_nxt = 1'b0;
          w_prio_nxt    = demote(w_prio_nxt, int'(r_own_idx));
        end
      end
    end else begin
      if (r_own_vld) begin
        w_own_vld_nxt = 1'b0;
        w_prio_nxt    = demote(w_prio_nxt, int'(r_own_idx));
      end
      if (w_valid) begin
        if (w_fire && w_win_wt == '0) begin
          w_prio_nxt = demote(w_prio_nxt, int'(w_win_idx));
        end else begin
          w_own_vld_nxt = 1'b1;
          w_own_idx_nxt = w_win_idx;
          w_credit_nxt  = w_fire ? (w_win_wt - 1'b1) : w_win_wt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio    <= '1;
      r_own_vld <= 1'b0;
      r_own_idx <= '0;
      r_credit  <= '0;
    end else begin
      r_prio    <= w_prio_nxt;
      r_own_vld <= w_own_vld_nxt;
      r_own_idx <= w_own_idx_nxt;
      r_credit  <= w_credit_nxt;
    end
  end

`ifdef WMARB_PERF_EN
  logic [NUM_REQS*PERF_CTR_WIDTH-1:0] r_perf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf <= '0;
    end else if (w_fire) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (grant_onehot[i])
          r_perf[i*PERF_CTR_WIDTH +: PERF_CTR_WIDTH] <=
            r_perf[i*PERF_CTR_WIDTH +: PERF_CTR_WIDTH] + PERF_CTR_WIDTH'(1);
      end
    end
  end

  assign perf_grants = r_perf;
`endif

endmodule

// File: doc/vx_weighted_matrix_arbiter.md
# vx_weighted_matrix_arbiter

Weighted, handshake-aware matrix (least-recently-granted) arbiter for Vortex request fan-in points such as the cache bank, memory and issue arbitration paths. Each requester wins and then holds the grant for up to `weight+1` accepted transfers. After its tenure it drops to lowest priority. A stalled grant (`grant_valid && !grant_ready`) stays locked until it is accepted or its request drops.

## Interface
- `NUM_REQS`, 4: number of requesters; must be ≥2.
- `WEIGHT_WIDTH`, 2: width of each per-requester weight field.
- `PERF_CTR_WIDTH`, 16: width of each grant counter; used only with `WMARB_PERF_EN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `requests`  in  NUM_REQS  per-requester request bits.
- `weights`  in  NUM_REQS*WEIGHT_WIDTH  extra grants allowed per tenure; field i is `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`.
- `grant_ready`  in  1  downstream accepts the current grant.
- `grant_valid`  out  1  a grant is presented.
- `grant_onehot`  out  NUM_REQS  granted requester, one-hot.
- `grant_index`  out  $clog2(NUM_REQS)  granted requester, binary.
- `grant_last`  out  1  an accepted transfer this cycle ends the tenure.
- `perf_grants`  out  NUM_REQS*PERF_CTR_WIDTH  accepted grants per requester; present only with `WMARB_PERF_EN`.

## Operation
- Priority matrix: `prio[i][j]` (i<j) is 1 when i beats j; there are NUM_REQS*(NUM_REQS-1)/2 flops. Reset value is all 1, so the lowest index has highest priority.
- `winner` is the requester with its request set and no requesting higher-priority requester.
- Owner state: `own_vld`, `own_idx`, `credit[WEIGHT_WIDTH-1:0]`.
- Owner is active when `own_vld && requests[own_idx]`.
  - If the owner is active, the grant goes to `own_idx`.
  - Otherwise the grant goes to `winner`.
- `grant_valid` = `|requests`. `grant_onehot` and `grant_index` are zero when `grant_valid`=0.
- `fire` = `grant_valid && grant_ready`.
- `grant_last` = `fire` and one of the following holds:
  - the owner is active and `credit`==0;
  - the owner is not active and the winner's weight is 0.
- Next-state rules, first match wins:
  - Owner active, fire, `credit`>0: decrement `credit`.
  - Owner active, fire, `credit`==0: release (clear `own_vld`) and demote `own_idx`.
  - Owner active, no fire: hold.
  - `own_vld` set but owner's request low: clear `own_vld` and demote `own_idx`. In the same cycle, the new winner is processed by the rules below.
  - No active owner, fire, winner weight 0: demote the winner; no owner is created.
  - No active owner, fire, winner weight >0: `own_vld`←1, `own_idx`←winner, `credit`←weight−1, matrix unchanged.
  - No active owner, stall (`grant_valid && !grant_ready`): `own_vld`←1, `own_idx`←winner, `credit`←weight (stall lock; no credit consumed).
- Demote(k): requester k loses to every other requester, i.e. `prio[k][*]`←0 and `prio[*][k]`←1.
- Weights are sampled only when the owner is acquired. Changing `weights` mid-tenure has no effect.

## Timing
- Zero-cycle arbitration: grant outputs are combinational from `requests`, owner state and matrix.
- Owner, credit and matrix update on the clock edge after the deciding cycle.
- While `reset`=0, all grant outputs are forced to 0. Reset values: `prio` all 1, `own_vld`=0, `credit`=0, `perf_grants`=0.
- Reset asserted mid-tenure clears ownership immediately; the first grant after release follows index order.
- Under full load with all weights = W, each requester receives W+1 consecutive grants, then rotates to the next in LRU order.

## Configuration
- `WMARB_PERF_EN` defined:
  - `perf_grants` exists.
  - Counter i increments on each `fire` with `grant_onehot[i]`.
  - Counters wrap modulo 2^PERF_CTR_WIDTH.
- `WMARB_PERF_EN` undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
All scenarios use NUM_REQS=4 and WEIGHT_WIDTH=2.
- After reset, `requests`=4'b1111, weights all 0, `grant_ready`=1 → grants 0,1,2,3,0,… one per cycle, with `grant_last`=1 every cycle.
- `requests`=4'b0011, weights = {0,0,2,0} (req1=2), ready=1 → grants 0,1,1,1,0,1,1,1…; `grant_last` is 1 on the first beat of req0 and on the 3rd beat of req1.
- Stall lock: cycle 0 `requests`=4'b0100, ready=0 → grant 2. Cycle 1 raise req0 → grant stays 2 until ready=1. The next grant goes to 0.
- Owner drop: req1 (weight 3) is granted once, then req1 drops with req3 requesting → req3 is granted in that same cycle. Req1 is then lower priority than req3.
- Async reset mid-tenure (req2 with credit 2): reset=0 → outputs 0 immediately. Release with `requests`=4'b1111 → grant 0.
- With `WMARB_PERF_EN`: 100 fires under the first scenario → each `perf_grants` field reads 25. With ready=0 throughout, counters stay 0.
